cam_pattern_gen: RTL and testbench
==================================

Name: cam_pattern_gen

Overview:
- Synthesizable OV7670-style camera source: drives pixel clock, vsync, href and byte-serial RGB565 data.
- Frame geometry and blanking are parametrised; four selectable test patterns.
- Sits in place of the real camera in front of the capture path, for board bring-up and self-test of the capture/VGA chain without the sensor.

Parameters:
- TAM_LINE, 320: active bytes per line; must be even (2 bytes per RGB565 pixel).
- TAM_ROW, 120: active rows per frame.
- BLACK_TAM_LINE, 4: blanking bytes per line, appended after active bytes.
- BLACK_TAM_ROW, 4: blanking rows per frame, placed before active rows; must be >= 2.
- PCLK_DIV, 2: clk cycles per CAM_pclk half-period; must be >= 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low.
- en, input, 1: run request; sampled only at frame boundaries.
- mode, input, 2: pattern select. 0 = solid, 1 = colour bars, 2 = byte counter, 3 = checkerboard.
- color, input, 16: RGB565 value used in solid mode.
- CAM_pclk, output, 1: generated pixel clock, free-running after reset.
- CAM_vsync, output, 1: frame sync, active high.
- CAM_href, output, 1: line valid, active high.
- CAM_px_data, output, 8: pixel byte.
- frame_cnt, output, 16: completed frames; wraps from 0xFFFF to 0.
- frame_done, output, 1: one-clk pulse at the end of each frame.

Behaviour:
- Reset (rst=0, async): CAM_pclk=0, CAM_vsync=0, CAM_href=0, CAM_px_data=0, frame_cnt=0, frame_done=0; counters cleared; state IDLE. Applies immediately, including mid-frame; the next frame restarts from row 0.
- Pclk generation:
  - A divider toggles CAM_pclk every PCLK_DIV clk cycles, so the period is 2*PCLK_DIV clk.
  - A "fall event" is the clk edge on which CAM_pclk goes 1->0.
  - All other registered outputs and counters change only on fall events, so they are stable at every pclk rising edge.
- Counters:
  - line_cnt runs 0..TAM_LINE+BLACK_TAM_LINE-1.
  - row_cnt runs 0..TAM_ROW+BLACK_TAM_ROW-1.
  - Both advance on fall events in RUN. line_cnt wraps and increments row_cnt; a row_cnt wrap ends the frame.
- States:
  - IDLE: counters held at 0; vsync, href and data all 0. On a fall event with en=1, go to RUN; that fall event presents row 0, line 0.
  - RUN: frame in progress. On the fall event that would wrap row_cnt to 0:
    - frame_done pulses for that clk and frame_cnt increments.
    - If en=1, stay in RUN and start the next frame at row 0, line 0.
    - If en=0, go to IDLE with outputs zeroed.
  - Deasserting en mid-frame does not truncate the frame.
- Output timing, per presented (row, line):
  - CAM_vsync=1 iff row < BLACK_TAM_ROW/2.
  - CAM_href=1 iff row >= BLACK_TAM_ROW and line < TAM_LINE.
  - CAM_px_data=0 when href=0.
- Pattern latching: mode and color are latched at each frame start (row 0, line 0 fall event). Changes mid-frame take effect on the next frame.
- Pixel addressing:
  - x = line>>1, y = row-BLACK_TAM_ROW.
  - Even line → high byte {R5,G6[5:3]}; odd line → low byte {G6[2:0],B5}.
- Patterns:
  - Solid: latched color.
  - Colour bars:
    - Eight vertical bars, each BAR_W = TAM_LINE/16 pixels wide (integer division). Pixels beyond 8*BAR_W use bar 7.
    - Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
    - Bar index comes from a per-line counter reset at line 0; no divider.
  - Byte counter: 8-bit value, cleared at frame start, output then incremented on every active byte; wraps 0xFF->0x00.
  - Checkerboard: (x[3]^y[3]) ? FFFF : 0000.
- Width rules:
  - Counter widths derived from parameters with $clog2.
  - frame_cnt wraps silently.

Test Plan (TAM_LINE=8, TAM_ROW=4, BLACK_TAM_LINE=4, BLACK_TAM_ROW=4, PCLK_DIV=2 unless stated):
1. Reset, en=0 for 100 clk → CAM_pclk toggles with period 4 clk; vsync, href and data stay 0; frame_cnt=0.
2. en=1, mode=0, color=16'hF800 → vsync high for exactly 2 rows (24 pclk). href first rises in row 4, with 4 active rows of 8 pclk each. Bytes alternate F8,00. frame_done pulses after 96 pclk; frame_cnt=1.
3. TAM_LINE=32, mode=1 → BAR_W=2. Per line, high bytes are FF,FF,FF,FF,07,07,... following the bar table; the last two pixels are 00,00.
4. mode=2 across two frames → active bytes 00..1F in frame 1 (32 active bytes), then restart at 00 in frame 2.
5. Change mode 0->3 mid-frame, then deassert en mid-frame → the current frame stays solid and completes. frame_done pulses, then IDLE with outputs 0 and frame_cnt incremented by exactly 1.
6. Assert rst low during an active row → all outputs 0 asynchronously. After release with en=1, the frame restarts at row 0 with vsync high.

Source files
------------

// File: rtl/cam_pattern_gen.sv
// Camera source emulator: OV7670-style pclk/vsync/href/RGB565 byte stream with four test patterns.
// Latency: outputs registered; every change lands on the clk edge where CAM_pclk falls.
// Backpressure: none, free-running source; en is honoured only at frame boundaries.
//
// Ports: clk/rst (async active-low) | en run request, mode pattern select, color solid RGB565
//        CAM_pclk/CAM_vsync/CAM_href/CAM_px_data camera bus | frame_cnt completed frames, frame_done end pulse
module cam_pattern_gen #(
    parameter int TAM_LINE       = 320,
    parameter int TAM_ROW        = 120,
    parameter int BLACK_TAM_LINE = 4,
    parameter int BLACK_TAM_ROW  = 4,
    parameter int PCLK_DIV       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [15:0] color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic [15:0] frame_cnt,
    output logic        frame_done
);

    localparam int LINE_TOT = TAM_LINE + BLACK_TAM_LINE;
    localparam int ROW_TOT  = TAM_ROW + BLACK_TAM_ROW;
    localparam int LW       = (LINE_TOT > 1) ? $clog2(LINE_TOT) : 1;
    localparam int RW       = (ROW_TOT > 1) ? $clog2(ROW_TOT) : 1;
    localparam int DW       = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int BAR_W    = TAM_LINE / 16;
    localparam int BPW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int BAR_LAST = (BAR_W > 0) ? BAR_W - 1 : 0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_nxt;
    logic [DW-1:0]  div_cnt;
    logic           div_wrap, fall_evt;
    logic [LW-1:0]  line_cnt, line_nxt;
    logic [RW-1:0]  row_cnt, row_nxt;
    logic           run_nxt, frame_start, frame_end;
    logic [1:0]     mode_l, mode_eff;
    logic [15:0]    color_l, color_eff;
    logic [7:0]     byte_cnt, byte_eff;
    logic [2:0]     bar_idx, bar_idx_eff, bar_idx_nxt;
    logic [BPW-1:0] bar_pos, bar_pos_eff, bar_pos_nxt;
    logic           vsync_nxt, href_nxt, chk_on;
    logic [15:0]    rgb;
    logic [7:0]     px_byte;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = 16'hFFFF;
            3'd1:    bar_color = 16'hFFE0;
            3'd2:    bar_color = 16'h07FF;
            3'd3:    bar_color = 16'h07E0;
            3'd4:    bar_color = 16'hF81F;
            3'd5:    bar_color = 16'hF800;
            3'd6:    bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    // Pixel clock divider; a fall event is the edge on which CAM_pclk goes high->low.
    assign div_wrap = (div_cnt == DW'(PCLK_DIV - 1));
    assign fall_evt = div_wrap && CAM_pclk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            CAM_pclk <= 1'b0;
        end else if (div_wrap) begin
            div_cnt  <= '0;
            CAM_pclk <= ~CAM_pclk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Next presented (row, line) and frame sequencing, evaluated for the coming fall event.
    always_comb begin
        state_nxt   = state;
        line_nxt    = line_cnt;
        row_nxt     = row_cnt;
        run_nxt     = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                line_nxt = '0;
                row_nxt  = '0;
                if (en) begin
                    state_nxt   = RUN;
                    run_nxt     = 1'b1;
                    frame_start = 1'b1;
                end
            end
            RUN: begin
                run_nxt = 1'b1;
                if (line_cnt == LW'(LINE_TOT - 1)) begin
                    line_nxt = '0;
                    if (row_cnt == RW'(ROW_TOT - 1)) begin
                        row_nxt   = '0;
                        frame_end = 1'b1;
                        if (en) begin
                            frame_start = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            run_nxt   = 1'b0;
                        end
                    end else begin
                        row_nxt = row_cnt + RW'(1);
                    end
                end else begin
                    line_nxt = line_cnt + LW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern generation for the next presented byte. At frame start the live inputs are
    // used directly, since the latches are only loaded on that same edge.
    always_comb begin
        mode_eff    = frame_start ? mode : mode_l;
        color_eff   = frame_start ? color : color_l;
        byte_eff    = frame_start ? 8'd0 : byte_cnt;
        bar_idx_eff = (line_nxt == '0) ? 3'd0 : bar_idx;
        bar_pos_eff = (line_nxt == '0) ? '0 : bar_pos;

        vsync_nxt = run_nxt && (row_nxt < RW'(BLACK_TAM_ROW / 2));
        href_nxt  = run_nxt && (row_nxt >= RW'(BLACK_TAM_ROW)) && (line_nxt < LW'(TAM_LINE));

        // x[3]^y[3] with x = line>>1 and y = row - BLACK_TAM_ROW.
        chk_on = ((((16'(line_nxt) >> 4) ^ ((16'(row_nxt) - 16'(BLACK_TAM_ROW)) >> 3)) & 16'd1) != 16'd0);

        // The bar position advances after the low (odd) byte of each pixel; bar 7 absorbs the remainder.
        bar_idx_nxt = bar_idx_eff;
        bar_pos_nxt = bar_pos_eff;
        if (line_nxt[0]) begin
            if (bar_pos_eff == BPW'(BAR_LAST)) begin
                bar_pos_nxt = '0;
                bar_idx_nxt = (bar_idx_eff == 3'd7) ? 3'd7 : bar_idx_eff + 3'd1;
            end else begin
                bar_pos_nxt = bar_pos_eff + BPW'(1);
            end
        end

        case (mode_eff)
            2'd0:    rgb = color_eff;
            2'd1:    rgb = bar_color((BAR_W == 0) ? 3'd7 : bar_idx_eff);
            2'd3:    rgb = chk_on ? 16'hFFFF : 16'h0000;
            default: rgb = 16'h0000;
        endcase

        px_byte = line_nxt[0] ? rgb[7:0] : rgb[15:8];
        if (mode_eff == 2'd2) begin
            px_byte = byte_eff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            line_cnt    <= '0;
            row_cnt     <= '0;
            mode_l      <= 2'd0;
            color_l     <= 16'h0000;
            byte_cnt    <= 8'd0;
            bar_idx     <= 3'd0;
            bar_pos     <= '0;
            CAM_vsync   <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_px_data <= 8'd0;
            frame_cnt   <= 16'd0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= fall_evt && frame_end;
            if (fall_evt) begin
                state       <= state_nxt;
                line_cnt    <= line_nxt;
                row_cnt     <= row_nxt;
                byte_cnt    <= href_nxt ? byte_eff + 8'd1 : byte_eff;
                bar_idx     <= bar_idx_nxt;
                bar_pos     <= bar_pos_nxt;
                CAM_vsync   <= vsync_nxt;
                CAM_href    <= href_nxt;
                CAM_px_data <= href_nxt ? px_byte : 8'd0;
                if (frame_start) begin
                    mode_l  <= mode;
                    color_l <= color;
                end
                if (frame_end) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_pattern_gen.sv
module tb_cam_pattern_gen;

    localparam int TR = 4;
    localparam int BL = 4;
    localparam int BR = 4;
    localparam int PD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] color = 16'h0000;

    logic        pclk0, vs0, hr0, done0;
    logic [7:0]  dat0;
    logic [15:0] fc0;
    logic        pclk1, vs1, hr1, done1;
    logic [7:0]  dat1;
    logic [15:0] fc1;

    cam_pattern_gen #(.TAM_LINE(8), .TAM_ROW(TR), .BLACK_TAM_LINE(BL), .BLACK_TAM_ROW(BR), .PCLK_DIV(PD)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .color(color),
        .CAM_pclk(pclk0), .CAM_vsync(vs0), .CAM_href(hr0), .CAM_px_data(dat0),
        .frame_cnt(fc0), .frame_done(done0));

    cam_pattern_gen #(.TAM_LINE(32), .TAM_ROW(TR), .BLACK_TAM_LINE(BL), .BLACK_TAM_ROW(BR), .PCLK_DIV(PD)) dut_wide (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .color(color),
        .CAM_pclk(pclk1), .CAM_vsync(vs1), .CAM_href(hr1), .CAM_px_data(dat1),
        .frame_cnt(fc1), .frame_done(done1));

    always #5 clk = ~clk;

    int  checks = 0;
    int  failures = 0;
    bit  abort = 1'b0;
    bit  sel = 1'b0;
    int  done_cnt = 0;
    int  bytec = 0;

    logic        s_pclk, s_vs, s_hr, s_done;
    logic [7:0]  s_dat;
    logic [15:0] s_fc;

    always_comb begin
        s_pclk = sel ? pclk1 : pclk0;
        s_vs   = sel ? vs1 : vs0;
        s_hr   = sel ? hr1 : hr0;
        s_dat  = sel ? dat1 : dat0;
        s_fc   = sel ? fc1 : fc0;
        s_done = sel ? done1 : done0;
    end

    always @(negedge clk) if (s_done) done_cnt++;

    // Expected byte of an active position, straight from the pattern definitions.
    function automatic logic [7:0] exp_byte(int row, int line, int m, logic [15:0] c, int bc, int tl);
        int x, y, bw, b;
        logic [15:0] px;
        x = line / 2;
        y = row - BR;
        px = 16'h0000;
        if (m == 2) return 8'(bc % 256);
        if (m == 0) px = c;
        else if (m == 3) px = ((((x / 8) + (y / 8)) % 2) == 1) ? 16'hFFFF : 16'h0000;
        else begin
            bw = tl / 16;
            b = (bw == 0) ? 7 : x / bw;
            if (b > 7) b = 7;
            case (b)
                0: px = 16'hFFFF; 1: px = 16'hFFE0; 2: px = 16'h07FF; 3: px = 16'h07E0;
                4: px = 16'hF81F; 5: px = 16'hF800; 6: px = 16'h001F; default: px = 16'h0000;
            endcase
        end
        return (line % 2 == 0) ? px[15:8] : px[7:0];
    endfunction

    // Advance to the next pclk rising edge; samples are taken on the following clk falling edge.
    task automatic next_period(output int n);
        logic prev;
        prev = s_pclk;
        n = 0;
        while (n < 4 * PD + 4) begin
            @(negedge clk);
            n++;
            if (s_pclk && !prev) return;
            prev = s_pclk;
        end
        checks++;
        failures++;
        abort = 1'b1;
        $display("FAIL pclk_timeout: no pclk rise within %0d clk, required one", n);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Find the first pclk period showing vsync; returns how many periods it took.
    task automatic align(output int cnt);
        int n;
        cnt = 0;
        while (cnt < 200 && !abort) begin
            next_period(n);
            cnt++;
            if (s_vs === 1'b1) return;
        end
        if (!abort) begin
            checks++;
            failures++;
            abort = 1'b1;
            $display("FAIL align: vsync never rose in %0d periods, required within 200", cnt);
        end
        cnt = -1;
    endtask

    task automatic check_period(int f, int k, int tl, int lm, logic [15:0] lc);
        int row, line;
        logic ev, eh;
        logic [7:0] ed;
        row = k / (tl + BL);
        line = k % (tl + BL);
        ev = (row < BR / 2);
        eh = (row >= BR) && (line < tl);
        ed = eh ? exp_byte(row, line, lm, lc, bytec, tl) : 8'h00;
        if (eh) bytec++;
        checks += 3;
        if (s_vs !== ev) begin
            failures++;
            $display("FAIL vsync f%0d row%0d line%0d: got %b required %b", f, row, line, s_vs, ev);
        end
        if (s_hr !== eh) begin
            failures++;
            $display("FAIL href f%0d row%0d line%0d: got %b required %b", f, row, line, s_hr, eh);
        end
        if (s_dat !== ed) begin
            failures++;
            $display("FAIL data f%0d row%0d line%0d mode%0d: got %h required %h", f, row, line, lm, s_dat, ed);
        end
    endtask

    // Checks nf consecutive frames from IDLE. At period chg_k inputs change (chg_mode<0: random);
    // at period drop_k of the last frame en is dropped (drop_k<0: en stays high).
    task automatic run_frames(int nf, int chg_k, int chg_mode, int drop_k);
        int tl, fl, n, a, base_done, lm;
        logic [15:0] lc;
        tl = sel ? 32 : 8;
        fl = (tl + BL) * (TR + BR);
        base_done = done_cnt;
        lm = 0;
        lc = 16'h0;
        align(a);
        if (a < 0) return;
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < fl; k++) begin
                if (f > 0 || k > 0) next_period(n);
                if (abort) return;
                if (k == 0) begin
                    lm = int'(mode);
                    lc = color;
                    bytec = 0;
                    if (f > 0) begin
                        checks++;
                        if (s_fc !== 16'(f) || done_cnt - base_done != f) begin
                            failures++;
                            $display("FAIL frame_cnt f%0d: got cnt=%0d pulses=%0d required %0d", f, s_fc, done_cnt - base_done, f);
                        end
                    end
                end
                check_period(f, k, tl, lm, lc);
                if (k == chg_k) begin
                    mode = (chg_mode < 0) ? 2'($urandom) : 2'(chg_mode);
                    color = 16'($urandom);
                end
                if (f == nf - 1 && k == drop_k) en = 1'b0;
            end
        end
        next_period(n);
        if (abort) return;
        checks += 2;
        if (s_fc !== 16'(nf) || done_cnt - base_done != nf) begin
            failures++;
            $display("FAIL frame_end: got cnt=%0d pulses=%0d required %0d", s_fc, done_cnt - base_done, nf);
        end
        if (drop_k < 0) begin
            if (s_vs !== 1'b1) begin
                failures++;
                $display("FAIL restart_vsync: got %b required 1", s_vs);
            end
        end else begin
            for (int i = 0; i < 8 && !abort; i++) begin
                if (i > 0) next_period(n);
                if ({s_vs, s_hr, s_dat} !== 10'd0) begin
                    failures++;
                    $display("FAIL idle_out p%0d: got vs=%b hr=%b d=%h required 0", i, s_vs, s_hr, s_dat);
                end
            end
            if (s_fc !== 16'(nf) || done_cnt - base_done != nf) begin
                failures++;
                $display("FAIL idle_cnt: got cnt=%0d pulses=%0d required %0d", s_fc, done_cnt - base_done, nf);
            end
        end
    endtask

    task automatic test_reset();
        int n, d0;
        sel = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({pclk0, vs0, hr0, dat0, fc0, done0} !== 28'd0) begin
            failures++;
            $display("FAIL reset_out: got pclk=%b vs=%b hr=%b d=%h fc=%0d done=%b required 0", pclk0, vs0, hr0, dat0, fc0, done0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d0 = done_cnt;
        next_period(n);
        for (int i = 0; i < 24 && !abort; i++) begin
            next_period(n);
            checks += 2;
            if (n != 2 * PD) begin
                failures++;
                $display("FAIL pclk_period: got %0d clk required %0d", n, 2 * PD);
            end
            if ({s_vs, s_hr, s_dat, s_fc} !== 26'd0 || done_cnt != d0) begin
                failures++;
                $display("FAIL idle_quiet: got vs=%b hr=%b d=%h fc=%0d required 0", s_vs, s_hr, s_dat, s_fc);
            end
        end
    endtask

    task automatic test_solid();
        sel = 1'b0;
        apply_reset();
        mode = 2'd0;
        color = 16'hF800;
        en = 1'b1;
        run_frames(1, -1, 0, 50);
    endtask

    task automatic test_bars();
        sel = 1'b1;
        apply_reset();
        mode = 2'd1;
        color = 16'($urandom);
        en = 1'b1;
        run_frames(1, -1, 0, 200);
    endtask

    task automatic test_byte_counter();
        sel = 1'b0;
        apply_reset();
        mode = 2'd2;
        color = 16'($urandom);
        en = 1'b1;
        run_frames(2, -1, 0, 50);
    endtask

    task automatic test_mid_change();
        sel = 1'b0;
        apply_reset();
        mode = 2'd0;
        color = 16'($urandom);
        en = 1'b1;
        run_frames(1, 40, 3, 60);
    endtask

    task automatic test_reset_mid();
        int n, a;
        sel = 1'b0;
        apply_reset();
        mode = 2'd3;
        en = 1'b1;
        n = 0;
        a = 0;
        while (!abort && s_hr !== 1'b1 && a < 200) begin
            next_period(n);
            a++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({s_pclk, s_vs, s_hr, s_dat, s_fc, s_done} !== 28'd0) begin
            failures++;
            $display("FAIL async_reset: got pclk=%b vs=%b hr=%b d=%h fc=%0d required 0", s_pclk, s_vs, s_hr, s_dat, s_fc);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // First pclk period still idle; the first fall event then presents row 0.
        align(a);
        checks++;
        if (a != 2) begin
            failures++;
            $display("FAIL restart_row0: vsync seen at period %0d required 2", a);
        end
        apply_reset();
        en = 1'b1;
        run_frames(1, -1, 0, 30);
    endtask

    task automatic test_random();
        sel = 1'b0;
        apply_reset();
        mode = 2'($urandom);
        color = 16'($urandom);
        en = 1'b1;
        run_frames(4, int'($urandom_range(1, 90)), -1, 70);
    endtask

    initial begin
        test_reset();
        if (!abort) test_solid();
        if (!abort) test_bars();
        if (!abort) test_byte_counter();
        if (!abort) test_mid_change();
        if (!abort) test_reset_mid();
        if (!abort) test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
